icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
Direct-mapped, read-only instruction cache between the mips core instruction port and the AXI bridge instruction port. Both sides use the sram-like protocol (req/addr_ok/data_ok).
- CPU-side physical address comes from the mmu.
- Misses refill a 4-word line using four sequential single-word reads on the memory side.
- Uncached fetches (kseg1 boot code) bypass the arrays.

Parameters:
INDEX_W  6  line index width; 2**INDEX_W lines
TAG_W  22  tag width; must equal 28-INDEX_W (4 offset bits)

Ports:
clk  in  1  clock; all state changes on rising edge
resetn  in  1  asynchronous active-low reset
cpu_req  in  1  fetch request
cpu_wr  in  1  must be 0; writes are not supported and are ignored
cpu_size  in  2  ignored; always word
cpu_addr  in  32  physical fetch address, word aligned
cpu_wdata  in  32  ignored
cpu_uncached  in  1  bypass cache; sampled with the request
cpu_addr_ok  out  1  request accepted this cycle when cpu_req & cpu_addr_ok
cpu_data_ok  out  1  one-cycle pulse; cpu_rdata valid
cpu_rdata  out  32  fetched instruction
mem_req  out  1  read request to the bridge
mem_wr  out  1  constant 0
mem_size  out  2  constant 2'b10
mem_addr  out  32  word read address
mem_wdata  out  32  constant 0
mem_rdata  in  32  returned word
mem_addr_ok  in  1  bridge accepted mem_req
mem_data_ok  in  1  mem_rdata valid

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; all valid bits cleared.
  - cpu_addr_ok=1, cpu_data_ok=0, cpu_rdata=0, mem_req=0, mem_addr=0.
  - Tag and data arrays are not reset.
- Address split: tag=addr[31:4+INDEX_W], index=addr[3+INDEX_W:4], word=addr[3:2].
- One outstanding CPU request at a time. cpu_addr_ok=1 only in IDLE.
- On handshake in IDLE, latch addr and uncached, then:
  - uncached → UC_REQ
  - cached → LOOKUP
- LOOKUP (1 cycle): hit = valid[index] & tag match.
  - Hit: cpu_data_ok=1 this cycle, cpu_rdata=data[index][word], next IDLE. Hit latency is data_ok one cycle after handshake.
  - Miss: clear valid[index], cnt=0, go to MISS_REQ.
- MISS_REQ: mem_req=1, mem_addr={tag,index,cnt,2'b00}, address stable until mem_addr_ok. On mem_addr_ok go to MISS_WAIT (mem_req=0).
- MISS_WAIT: on mem_data_ok:
  - Write data[index][cnt]=mem_rdata.
  - If cnt==word, also capture into the response register.
  - If cnt==3: write tag, set valid[index], go to RESP.
  - Else cnt+=1 and go to MISS_REQ.
- Refill order is always word 0..3; no critical-word-first.
- UC_REQ: mem_req=1, mem_addr=latched addr until mem_addr_ok, then UC_WAIT. On mem_data_ok, capture mem_rdata and go to RESP. Arrays and valid are untouched.
- RESP: cpu_data_ok=1 for one cycle, cpu_rdata=captured word, next IDLE.
- cpu_rdata holds its last value outside data_ok cycles.
- mem_data_ok outside the WAIT states is ignored. The bridge guarantees none arrives.
- cpu_req with cpu_wr=1 is accepted and handled as a read. The core never issues one.
- Reset asserted mid-refill: the line stays invalid (valid bit already cleared), and the bridge is reset by the same resetn.
- Throughput: at most one hit per 2 cycles. A miss costs at least 4×(bridge round trip)+2 cycles.

Decomposition:
- Shared package icache_pkg:
  - state enum: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, UC_REQ, UC_WAIT, RESP
  - OFFSET_W=4, WORDS_PER_LINE=4, MEM_SIZE_WORD=2'b10
- Sub-module icache_line_array holds the tag, valid and data storage:
  - combinational read by index
  - synchronous word write
  - tag+valid write
  - async valid clear
- The top level keeps the FSM and counters.

Test Plan:
1. Reset, fetch cached 0x1FC00004 → four mem reads at 0x1FC00000, 0x1FC00004, 0x1FC00008, 0x1FC0000C in order; cpu_data_ok once with the word from 0x1FC00004.
2. Then fetch 0x1FC00008 → hit: cpu_data_ok exactly 1 cycle after handshake, with the word returned for 0x1FC00008; mem_req stays 0.
3. Fetch 0x1FC00400 (same index 0, different tag) → refill of 0x1FC00400–0x1FC0040C. A following fetch of 0x1FC00000 misses again.
4. Uncached fetch 0x1FC00010 → single mem read at 0x1FC00010 and data returned. A following cached fetch of 0x1FC00010 still misses (4 reads).
5. Hold mem_addr_ok=0 for 5 cycles during MISS_REQ → mem_req and mem_addr stay stable, cpu_addr_ok=0 throughout, refill completes afterwards.
6. Assert resetn=0 mid-refill after 2 words → all outputs return to reset values immediately. After release, re-fetching that address misses and does a full 4-word refill.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
package icache_pkg;

  localparam int OFFSET_W       = 4;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_SEL_W     = 2;

  localparam logic [1:0]            MEM_SIZE_WORD = 2'b10;
  localparam logic [WORD_SEL_W-1:0] LAST_WORD     = WORD_SEL_W'(WORDS_PER_LINE - 1);

  // Controller states; one CPU request is in flight between IDLE and RESP.
  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    UC_REQ,
    UC_WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/icache_line_array.sv
// Tag, valid and data storage for the direct-mapped instruction cache.
// Reads are combinational by index; tag and data writes are synchronous.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 22
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [INDEX_W-1:0]    index,
  input  logic [WORD_SEL_W-1:0] rd_word,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  data_we,
  input  logic [WORD_SEL_W-1:0] wr_word,
  input  logic [31:0]           wr_data,
  input  logic                  tag_we,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic                  valid_clr
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*WORDS_PER_LINE];

  // Valid bits: cleared on reset, set when a refill completes, cleared when a miss starts.
  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[index] <= 1'b1;
    end else if (valid_clr) begin
      valid_q[index] <= 1'b0;
    end
  end

  // Tag and data payload writes during refill.
  // NOTE: storage arrays carry no reset; the valid bits alone decide whether contents are usable.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[{index, wr_word}] <= wr_data;
    end
    if (tag_we) begin
      tag_mem[index] <= wr_tag;
    end
  end

  assign rd_valid = valid_q[index];
  assign rd_tag   = tag_mem[index];
  assign rd_data  = data_mem[{index, rd_word}];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache between the core fetch port and
// the bridge. Misses refill a 4-word line word 0..3; uncached fetches bypass.
module icache_direct
  import icache_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 22   // must equal 28-INDEX_W
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_uncached,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  state_t                state_q, state_d;
  logic [31:0]           req_addr_q;
  logic [WORD_SEL_W-1:0] cnt_q;
  logic [31:0]           resp_q;
  logic [31:0]           last_q;

  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    req_index;
  logic [WORD_SEL_W-1:0] req_word;

  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [31:0]           rd_data;
  logic                  hit;
  logic                  data_we, tag_we, valid_clr;

  // Writes are treated as reads and size is always a word; these inputs carry no information.
  logic unused_inputs;
  assign unused_inputs = ^{cpu_wr, cpu_size, cpu_wdata};

  assign req_tag   = req_addr_q[31 -: TAG_W];
  assign req_index = req_addr_q[OFFSET_W +: INDEX_W];
  assign req_word  = req_addr_q[3:2];
  assign hit       = rd_valid && (rd_tag == req_tag);

  assign mem_wr    = 1'b0;
  assign mem_size  = MEM_SIZE_WORD;
  assign mem_wdata = '0;

  icache_line_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_lines (
    .clk       (clk),
    .resetn    (resetn),
    .index     (req_index),
    .rd_word   (req_word),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .data_we   (data_we),
    .wr_word   (cnt_q),
    .wr_data   (mem_rdata),
    .tag_we    (tag_we),
    .wr_tag    (req_tag),
    .valid_clr (valid_clr)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: combinational blocks use blocking assignments and assign a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (cpu_req)     state_d = cpu_uncached ? UC_REQ : LOOKUP;
      LOOKUP:                     state_d = hit ? IDLE : MISS_REQ;
      MISS_REQ:  if (mem_addr_ok) state_d = MISS_WAIT;
      MISS_WAIT: if (mem_data_ok) state_d = (cnt_q == LAST_WORD) ? RESP : MISS_REQ;
      UC_REQ:    if (mem_addr_ok) state_d = UC_WAIT;
      UC_WAIT:   if (mem_data_ok) state_d = RESP;
      RESP:                       state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Outputs and array write strobes decoded from the current state.
  always_comb begin
    cpu_addr_ok = 1'b0;
    cpu_data_ok = 1'b0;
    cpu_rdata   = last_q;
    mem_req     = 1'b0;
    mem_addr    = '0;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    valid_clr   = 1'b0;
    unique case (state_q)
      IDLE: cpu_addr_ok = 1'b1;
      LOOKUP: begin
        if (hit) begin
          cpu_data_ok = 1'b1;
          cpu_rdata   = rd_data;
        end else begin
          valid_clr = 1'b1;
        end
      end
      MISS_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_index, cnt_q, 2'b00};
      end
      MISS_WAIT: begin
        data_we = mem_data_ok;
        tag_we  = mem_data_ok && (cnt_q == LAST_WORD);
      end
      UC_REQ: begin
        mem_req  = 1'b1;
        mem_addr = req_addr_q;
      end
      RESP: begin
        cpu_data_ok = 1'b1;
        cpu_rdata   = resp_q;
      end
      default: ;
    endcase
  end

  // Request address, refill counter, response word and held read data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_addr_q <= '0;
      cnt_q      <= '0;
      resp_q     <= '0;
      last_q     <= '0;
    end else begin
      if (state_q == IDLE && cpu_req) begin
        req_addr_q <= cpu_addr;
      end
      if (state_q == LOOKUP && !hit) begin
        cnt_q <= '0;
      end
      if (state_q == MISS_WAIT && mem_data_ok) begin
        if (cnt_q == req_word) resp_q <= mem_rdata;
        if (cnt_q != LAST_WORD) cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == UC_WAIT && mem_data_ok) begin
        resp_q <= mem_rdata;
      end
      if (cpu_data_ok) begin
        last_q <= cpu_rdata;
      end
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: a randomized bridge model, an
// abstract cache model (valid/tag per line) and directed plus random fetches.
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_req, cpu_wr, cpu_uncached;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_addr_ok, cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  int checks = 0;
  int errors = 0;

  // Abstract cache model: which line holds which tag.
  bit          mvalid [64];
  logic [21:0] mtag   [64];

  // Bridge model state.
  int          br_phase = 0;
  int          br_delay = 0;
  int          hold_next = 0;
  int          br_data_cnt = 0;
  logic [31:0] br_addr = '0;
  logic [31:0] mem_log [$];

  icache_direct #(.INDEX_W(6), .TAG_W(22)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cpu_req      (cpu_req),
    .cpu_wr       (cpu_wr),
    .cpu_size     (cpu_size),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_uncached (cpu_uncached),
    .cpu_addr_ok  (cpu_addr_ok),
    .cpu_data_ok  (cpu_data_ok),
    .cpu_rdata    (cpu_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Backing memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ a[31:16], ~a[15:0]};
  endfunction

  // Bridge: random accept and return delays, one outstanding read at a time.
  initial begin
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        br_phase    = 0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
      end else begin
        if (br_phase == 4) begin
          mem_data_ok = 1'b0;
          br_phase    = 0;
        end
        if (br_phase == 2) begin
          mem_addr_ok = 1'b0;
          check("mem_req_drop", 32'(mem_req), 32'd0);
          br_delay = $urandom_range(0, 2);
          br_phase = 3;
        end
        if (br_phase == 3) begin
          if (br_delay == 0) begin
            mem_data_ok = 1'b1;
            mem_rdata   = mem_word(br_addr);
            br_data_cnt++;
            br_phase    = 4;
          end else begin
            br_delay--;
          end
        end
        if (br_phase == 0 && mem_req) begin
          br_addr   = mem_addr;
          br_delay  = (hold_next > 0) ? hold_next : int'($urandom_range(0, 2));
          hold_next = 0;
          br_phase  = 1;
        end
        if (br_phase == 1) begin
          check("mem_req_held", 32'(mem_req), 32'd1);
          check("mem_addr_held", mem_addr, br_addr);
          if (br_delay == 0) begin
            mem_addr_ok = 1'b1;
            mem_log.push_back(br_addr);
            br_phase = 2;
          end else begin
            br_delay--;
          end
        end
      end
    end
  end

  // One complete fetch, compared against the abstract model.
  task automatic fetch(input logic [31:0] a, input bit unc, output logic [31:0] got, output int lat);
    logic [5:0]  idx;
    logic [21:0] tg;
    bit          exp_hit;
    logic [31:0] exp_log [$];
    idx = a[9:4];
    tg  = a[31:10];
    exp_hit = !unc && mvalid[idx] && (mtag[idx] == tg);
    if (!exp_hit) begin
      if (unc) exp_log.push_back(a);
      else for (int i = 0; i < 4; i++) exp_log.push_back({a[31:4], 4'b0000} + 32'(i * 4));
    end
    mem_log.delete();
    got = '0;
    @(negedge clk);
    check("idle_addr_ok", 32'(cpu_addr_ok), 32'd1);
    cpu_req      = 1'b1;
    cpu_addr     = a;
    cpu_uncached = unc;
    cpu_size     = 2'($urandom);
    cpu_wdata    = $urandom;
    @(posedge clk);
    #1;
    cpu_req      = 1'b0;
    cpu_addr     = $urandom;
    cpu_uncached = 1'($urandom_range(0, 1));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      check("busy_addr_ok", 32'(cpu_addr_ok), 32'd0);
    end while (!cpu_data_ok && lat < 300);
    check("data_ok_seen", 32'(cpu_data_ok), 32'd1);
    if (!cpu_data_ok) return;
    got = cpu_rdata;
    check("rdata", got, mem_word(a));
    if (exp_hit) check("hit_latency", 32'(lat), 32'd1);
    check("mem_read_count", 32'(mem_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < mem_log.size(); i++)
      check("mem_read_addr", mem_log[i], exp_log[i]);
    if (!unc) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
    end
    @(negedge clk);
    check("data_ok_pulse", 32'(cpu_data_ok), 32'd0);
    check("addr_ok_back", 32'(cpu_addr_ok), 32'd1);
    check("rdata_hold", cpu_rdata, got);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr_ok"}, 32'(cpu_addr_ok), 32'd1);
    check({tag, "_data_ok"}, 32'(cpu_data_ok), 32'd0);
    check({tag, "_rdata"}, cpu_rdata, 32'd0);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    int          lat;
    int          base;
    int          n;
    logic [21:0] tag_pool [3];
    logic [5:0]  idx_pool [5];

    tag_pool = '{22'h07F000, 22'h07F001, 22'h000123};
    idx_pool = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd63};
    foreach (mvalid[i]) mvalid[i] = 1'b0;

    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_size = 2'b10; cpu_addr = '0;
    cpu_wdata = '0; cpu_uncached = 1'b0;
    resetn = 1'b0;
    #1;
    check_reset_outputs("reset");
    check("mem_wr", 32'(mem_wr), 32'd0);
    check("mem_size", 32'(mem_size), 32'd2);
    check("mem_wdata", mem_wdata, 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // 1: cold miss refills the whole line in word order.
    fetch(32'h1FC00004, 1'b0, got, lat);
    check("t1_data", got, 32'h1FC4FFFB);
    check("t1_rd0", mem_log[0], 32'h1FC00000);
    check("t1_rd1", mem_log[1], 32'h1FC00004);
    check("t1_rd2", mem_log[2], 32'h1FC00008);
    check("t1_rd3", mem_log[3], 32'h1FC0000C);

    // 2: hit in the freshly filled line.
    fetch(32'h1FC00008, 1'b0, got, lat);
    check("t2_data", got, 32'h1FC8FFF7);
    check("t2_latency", 32'(lat), 32'd1);
    check("t2_no_reads", 32'(mem_log.size()), 32'd0);

    // 3: conflicting tag at index 0 evicts, then the old line misses again.
    fetch(32'h1FC00400, 1'b0, got, lat);
    check("t3_rd0", mem_log[0], 32'h1FC00400);
    check("t3_rd3", mem_log[3], 32'h1FC0040C);
    fetch(32'h1FC00000, 1'b0, got, lat);
    check("t3_remiss", 32'(mem_log.size()), 32'd4);

    // 4: uncached fetch does not allocate.
    fetch(32'h1FC00010, 1'b1, got, lat);
    check("t4_data", got, 32'h1FD0FFEF);
    check("t4_reads", 32'(mem_log.size()), 32'd1);
    check("t4_rd0", mem_log[0], 32'h1FC00010);
    fetch(32'h1FC00010, 1'b0, got, lat);
    check("t4_cached_miss", 32'(mem_log.size()), 32'd4);

    // 5: bridge stalls the first refill request for 5 cycles.
    hold_next = 5;
    fetch(32'h1FC00030, 1'b0, got, lat);
    check("t5_reads", 32'(mem_log.size()), 32'd4);

    // 6: reset in the middle of a refill that replaces a valid line.
    fetch(32'h1FC00020, 1'b0, got, lat);
    base = br_data_cnt;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h1FC00820; cpu_uncached = 1'b0;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    n = 0;
    while (br_data_cnt - base < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_two_words", 32'(br_data_cnt - base), 32'd2);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("t6_reset");
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    fetch(32'h1FC00020, 1'b0, got, lat);
    check("t6_refetch_reads", 32'(mem_log.size()), 32'd4);
    fetch(32'h1FC00820, 1'b0, got, lat);
    check("t6_other_reads", 32'(mem_log.size()), 32'd4);

    // Random fetches over a small address pool so hits, conflicts and bypasses mix.
    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      bit          unc;
      a   = {tag_pool[$urandom_range(0, 2)], idx_pool[$urandom_range(0, 4)],
             2'($urandom_range(0, 3)), 2'b00};
      unc = ($urandom_range(0, 4) == 0);
      fetch(a, unc, got, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
